// File: rtl/compressed_inst_aligner_pkg.sv
// Shared types and constants for the RV32IC fetch-side instruction aligner.
package aligner_pkg;
  typedef enum logic {RUN, SKIP} align_state_e;
  localparam int HW_DEPTH = 3;
  localparam logic [1:0] OPC_32B = 2'b11;
endpackage

// File: rtl/compressed_inst_aligner_fifo.sv
// halfword_fifo: 3-entry 16-bit shift queue; entry 0 is the oldest halfword.
module halfword_fifo
  import aligner_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  push_n,
  input  logic [1:0]  pop_n,
  input  logic        flush,
  input  logic [31:0] push_data,
  output logic [31:0] head,
  output logic [1:0]  cnt
);
  logic [HW_DEPTH-1:0][15:0] q_q, q_d, sh;
  logic [1:0]                cnt_q, cnt_d, rem;

  // Pop first by shifting toward entry 0, then append pushes behind the survivors.
  always_comb begin
    case (pop_n)
      2'd1:    sh = {16'h0, q_q[2], q_q[1]};
      2'd2:    sh = {32'h0, q_q[2]};
      default: sh = q_q;
    endcase
    rem = cnt_q - pop_n;
  end

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      q_d = sh;
      for (int i = 0; i < HW_DEPTH; i++) begin
        if (i == int'(rem) && push_n != 2'd0)
          q_d[i] = push_data[15:0];
        else if (i == int'(rem) + 1 && push_n == 2'd2)
          q_d[i] = push_data[31:16];
      end
      cnt_d = rem + push_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= '0;
      cnt_q <= 2'd0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign head = {q_q[1], q_q[0]};
  assign cnt  = cnt_q;
endmodule

// File: rtl/compressed_inst_aligner.sv
// compressed_inst_aligner: realigns 16/32-bit RV32IC instructions from 32-bit fetch words.
// Define ALIGNER_STATS_EN to add the popped-instruction counters stat_c_cnt / stat_i_cnt.
module compressed_inst_aligner
  import aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fw_valid,
  input  logic [31:0] fw_data,
  output logic        fw_ready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_compressed
`ifdef ALIGNER_STATS_EN
  ,
  output logic [31:0] stat_c_cnt,
  output logic [31:0] stat_i_cnt
`endif
);
  align_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  head, push_data;
  logic [1:0]   hw_cnt, push_n, pop_n;
  logic         head_is_c, accept, pop_fire;

  halfword_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_n    (push_n),
    .pop_n     (pop_n),
    .flush     (redirect_valid),
    .push_data (push_data),
    .head      (head),
    .cnt       (hw_cnt)
  );

  assign head_is_c = head[1:0] != OPC_32B;
  // A 32-bit head with only its low half queued waits for the next word.
  assign inst_valid = (hw_cnt != 2'd0) && (head_is_c || hw_cnt >= 2'd2) && !redirect_valid;
  assign inst_is_compressed = (hw_cnt != 2'd0) && head_is_c;
  assign inst_data = (hw_cnt == 2'd0) ? 32'h0 : (head_is_c ? {16'h0, head[15:0]} : head);
  assign inst_pc   = pc_q;
  assign fw_ready  = reset_n && ((hw_cnt <= 2'd1) || redirect_valid);
  assign accept    = fw_valid && fw_ready;
  assign pop_fire  = inst_valid && inst_ready;
  assign pop_n     = pop_fire ? (head_is_c ? 2'd1 : 2'd2) : 2'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = redirect_pc[1] ? SKIP : RUN;
    else if (state_q == SKIP && accept)
      state_d = RUN;
  end

  // A word arriving with a redirect is consumed but dropped; in SKIP only its upper half is kept.
  always_comb begin
    push_n    = 2'd0;
    push_data = fw_data;
    if (accept && !redirect_valid) begin
      if (state_q == SKIP) begin
        push_n    = 2'd1;
        push_data = {16'h0, fw_data[31:16]};
      end else begin
        push_n    = 2'd2;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc & ~32'h1;
    else if (pop_fire)  pc_d = pc_q + (head_is_c ? 32'd2 : 32'd4);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_PC & ~32'h1;
    else          pc_q <= pc_d;
  end

`ifdef ALIGNER_STATS_EN
  logic [31:0] stat_c_cnt_q, stat_c_cnt_d, stat_i_cnt_q, stat_i_cnt_d;

  always_comb begin
    stat_c_cnt_d = stat_c_cnt_q;
    stat_i_cnt_d = stat_i_cnt_q;
    if (pop_fire && head_is_c)  stat_c_cnt_d = stat_c_cnt_q + 32'd1;
    if (pop_fire && !head_is_c) stat_i_cnt_d = stat_i_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_c_cnt_q <= 32'h0;
      stat_i_cnt_q <= 32'h0;
    end else begin
      stat_c_cnt_q <= stat_c_cnt_d;
      stat_i_cnt_q <= stat_i_cnt_d;
    end
  end

  assign stat_c_cnt = stat_c_cnt_q;
  assign stat_i_cnt = stat_i_cnt_q;
`endif
endmodule

// File: tb/tb_compressed_inst_aligner.sv
// Directed bench for compressed_inst_aligner: reset, straddle, skip redirect, backpressure, collisions.
module tb_compressed_inst_aligner;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fw_valid = 1'b0;
  logic [31:0] fw_data = 32'h0;
  logic        fw_ready;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;
`ifdef ALIGNER_STATS_EN
  logic [31:0] stat_c_cnt, stat_i_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;

  compressed_inst_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .fw_valid           (fw_valid),
    .fw_data            (fw_data),
    .fw_ready           (fw_ready),
    .inst_valid         (inst_valid),
    .inst_ready         (inst_ready),
    .inst_data          (inst_data),
    .inst_pc            (inst_pc),
    .inst_is_compressed (inst_is_compressed)
`ifdef ALIGNER_STATS_EN
    ,
    .stat_c_cnt         (stat_c_cnt),
    .stat_i_cnt         (stat_i_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0; redirect_pc = 32'h0; fw_valid = 1'b0; fw_data = 32'h0; inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0; #2; reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (fw_ready !== 1'b0)            begin n_err++; $display("FAIL rst_fw_ready: got %b want 0", fw_ready); end
    n_cmp++; if (inst_valid !== 1'b0)          begin n_err++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0)          begin n_err++; $display("FAIL rst_inst_data: got %h want 0", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0)            begin n_err++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
    n_cmp++; if (inst_is_compressed !== 1'b0)  begin n_err++; $display("FAIL rst_is_c: got %b want 0", inst_is_compressed); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_compressed_pair();
    fw_valid = 1'b1; fw_data = 32'h0001_4501; inst_ready = 1'b1;
    #3;
    n_cmp++; if (fw_ready !== 1'b1)   begin n_err++; $display("FAIL pair_fw_ready0: got %b want 1", fw_ready); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL pair_latency: got %b want 0", inst_valid); end
    tick();
    fw_valid = 1'b0;
    #3;
    n_cmp++; if (inst_valid !== 1'b1)         begin n_err++; $display("FAIL pair_v0: got %b want 1", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0000_4501) begin n_err++; $display("FAIL pair_d0: got %h want 00004501", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0)           begin n_err++; $display("FAIL pair_pc0: got %h want 0", inst_pc); end
    n_cmp++; if (inst_is_compressed !== 1'b1) begin n_err++; $display("FAIL pair_c0: got %b want 1", inst_is_compressed); end
    tick();
    #3;
    n_cmp++; if (inst_data !== 32'h0000_0001) begin n_err++; $display("FAIL pair_d1: got %h want 00000001", inst_data); end
    n_cmp++; if (inst_pc !== 32'h2)           begin n_err++; $display("FAIL pair_pc1: got %h want 2", inst_pc); end
    n_cmp++; if (inst_is_compressed !== 1'b1) begin n_err++; $display("FAIL pair_c1: got %b want 1", inst_is_compressed); end
    n_cmp++; if (fw_ready !== 1'b1)           begin n_err++; $display("FAIL pair_fw_ready1: got %b want 1", fw_ready); end
    tick();
    #3;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL pair_empty: got %b want 0", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h4)   begin n_err++; $display("FAIL pair_pc_end: got %h want 4", inst_pc); end
    tick();
  endtask

  task automatic test_straddle();
    do_reset();
    fw_valid = 1'b1; fw_data = 32'h0513_4501; inst_ready = 1'b1;
    tick();
    fw_data = 32'h0010_0010;
    #3;
    n_cmp++; if (fw_ready !== 1'b0)           begin n_err++; $display("FAIL str_full: got %b want 0", fw_ready); end
    n_cmp++; if (inst_data !== 32'h0000_4501) begin n_err++; $display("FAIL str_c: got %h want 00004501", inst_data); end
    tick();
    #3;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL str_wait: got %b want 0", inst_valid); end
    n_cmp++; if (fw_ready !== 1'b1)   begin n_err++; $display("FAIL str_ready: got %b want 1", fw_ready); end
    tick();
    fw_valid = 1'b0;
    #3;
    n_cmp++; if (inst_valid !== 1'b1)         begin n_err++; $display("FAIL str_v32: got %b want 1", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0010_0513) begin n_err++; $display("FAIL str_d32: got %h want 00100513", inst_data); end
    n_cmp++; if (inst_pc !== 32'h2)           begin n_err++; $display("FAIL str_pc32: got %h want 2", inst_pc); end
    n_cmp++; if (inst_is_compressed !== 1'b0) begin n_err++; $display("FAIL str_c32: got %b want 0", inst_is_compressed); end
    tick();
    #3;
    n_cmp++; if (inst_data !== 32'h0000_0010) begin n_err++; $display("FAIL str_tail_d: got %h want 00000010", inst_data); end
    n_cmp++; if (inst_pc !== 32'h6)           begin n_err++; $display("FAIL str_tail_pc: got %h want 6", inst_pc); end
    tick();
  endtask

  task automatic test_redirect_skip();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; inst_ready = 1'b1;
    #3;
    n_cmp++; if (fw_ready !== 1'b1) begin n_err++; $display("FAIL skip_ready: got %b want 1", fw_ready); end
    tick();
    redirect_valid = 1'b0; fw_valid = 1'b1; fw_data = 32'h4505_0001;
    #3;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL skip_empty: got %b want 0", inst_valid); end
    tick();
    fw_valid = 1'b0;
    #3;
    n_cmp++; if (inst_data !== 32'h0000_4505) begin n_err++; $display("FAIL skip_d: got %h want 00004505", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0000_0102)   begin n_err++; $display("FAIL skip_pc: got %h want 00000102", inst_pc); end
    n_cmp++; if (inst_is_compressed !== 1'b1) begin n_err++; $display("FAIL skip_c: got %b want 1", inst_is_compressed); end
    tick();
    fw_valid = 1'b1; fw_data = 32'h0001_4501;
    #3;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL skip_single: got %b want 0", inst_valid); end
    tick();
    fw_valid = 1'b0;
    #3;
    n_cmp++; if (inst_data !== 32'h0000_4501) begin n_err++; $display("FAIL skip_run_d0: got %h want 00004501", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0000_0104)   begin n_err++; $display("FAIL skip_run_pc0: got %h want 00000104", inst_pc); end
    tick();
    #3;
    n_cmp++; if (inst_data !== 32'h0000_0001) begin n_err++; $display("FAIL skip_run_d1: got %h want 00000001", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0000_0106)   begin n_err++; $display("FAIL skip_run_pc1: got %h want 00000106", inst_pc); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] words [4];
    logic [31:0] exp_d [6];
    logic [31:0] exp_pc [6];
    logic        exp_c [6];
    int wi, got;
    words = '{32'h0513_4501, 32'h4505_0010, 32'h0001_4585, 32'h00a5_8533};
    exp_d  = '{32'h0000_4501, 32'h0010_0513, 32'h0000_4505, 32'h0000_4585, 32'h0000_0001, 32'h00a5_8533};
    exp_pc = '{32'h0, 32'h2, 32'h6, 32'h8, 32'hA, 32'hC};
    exp_c  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    wi = 0; got = 0;
    do_reset();
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      fw_valid = (wi < 4);
      fw_data  = words[(wi < 4) ? wi : 0];
      inst_ready = (cyc >= 5);
      #3;
      if (cyc == 3) begin
        n_cmp++; if (fw_ready !== 1'b0)   begin n_err++; $display("FAIL bp_stall_ready: got %b want 0", fw_ready); end
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_stall_valid: got %b want 1", inst_valid); end
      end
      if (inst_valid && inst_ready) begin
        n_cmp++;
        if (inst_data !== exp_d[got] || inst_pc !== exp_pc[got] || inst_is_compressed !== exp_c[got]) begin
          n_err++;
          $display("FAIL bp_inst%0d: got %h@%h c=%b want %h@%h c=%b", got, inst_data, inst_pc,
                   inst_is_compressed, exp_d[got], exp_pc[got], exp_c[got]);
        end
        got++;
      end
      if (fw_valid && fw_ready) wi++;
      tick();
    end
    fw_valid = 1'b0;
    #3;
    n_cmp++; if (got != 6)            begin n_err++; $display("FAIL bp_count: got %0d want 6", got); end
    n_cmp++; if (wi != 4)             begin n_err++; $display("FAIL bp_words: got %0d want 4", wi); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h10)  begin n_err++; $display("FAIL bp_pc_end: got %h want 10", inst_pc); end
    tick();
  endtask

  task automatic test_redirect_collision();
    do_reset();
    fw_valid = 1'b1; fw_data = 32'h0001_4501;
    tick();
    fw_data = 32'h1234_5678; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0201;
    #3;
    n_cmp++; if (fw_ready !== 1'b1)   begin n_err++; $display("FAIL col_ready: got %b want 1", fw_ready); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL col_suppress: got %b want 0", inst_valid); end
    tick();
    idle_inputs(); inst_ready = 1'b1;
    #3;
    n_cmp++; if (inst_valid !== 1'b0)       begin n_err++; $display("FAIL col_flushed: got %b want 0", inst_valid); end
    n_cmp++; if (inst_pc !== 32'h0000_0200) begin n_err++; $display("FAIL col_pc: got %h want 00000200", inst_pc); end
    n_cmp++; if (fw_ready !== 1'b1)         begin n_err++; $display("FAIL col_empty: got %b want 1", fw_ready); end
    fw_valid = 1'b1; fw_data = 32'h0001_4585;
    tick();
    fw_valid = 1'b0;
    #3;
    n_cmp++; if (inst_data !== 32'h0000_4585) begin n_err++; $display("FAIL col_next_d: got %h want 00004585", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0000_0200)   begin n_err++; $display("FAIL col_next_pc: got %h want 00000200", inst_pc); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    fw_valid = 1'b1; fw_data = 32'h0513_4501;
    tick();
    fw_valid = 1'b0; inst_ready = 1'b1;
    tick();
    fw_valid = 1'b1; fw_data = 32'h0010_0010; inst_ready = 1'b0;
    tick();
    fw_valid = 1'b0;
    #3;
    n_cmp++; if (inst_data !== 32'h0010_0513) begin n_err++; $display("FAIL ar_pre_d: got %h want 00100513", inst_data); end
    n_cmp++; if (fw_ready !== 1'b0)           begin n_err++; $display("FAIL ar_pre_full: got %b want 0", fw_ready); end
`ifdef ALIGNER_STATS_EN
    n_cmp++; if (stat_c_cnt !== 32'd1) begin n_err++; $display("FAIL ar_stat_c: got %0d want 1", stat_c_cnt); end
    n_cmp++; if (stat_i_cnt !== 32'd0) begin n_err++; $display("FAIL ar_stat_i: got %0d want 0", stat_i_cnt); end
`endif
    #1; reset_n = 1'b0; #1;
    n_cmp++; if (inst_valid !== 1'b0)         begin n_err++; $display("FAIL ar_valid: got %b want 0", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0)         begin n_err++; $display("FAIL ar_data: got %h want 0", inst_data); end
    n_cmp++; if (inst_pc !== 32'h0)           begin n_err++; $display("FAIL ar_pc: got %h want 0", inst_pc); end
    n_cmp++; if (inst_is_compressed !== 1'b0) begin n_err++; $display("FAIL ar_is_c: got %b want 0", inst_is_compressed); end
    n_cmp++; if (fw_ready !== 1'b0)           begin n_err++; $display("FAIL ar_fw_ready: got %b want 0", fw_ready); end
`ifdef ALIGNER_STATS_EN
    n_cmp++; if (stat_c_cnt !== 32'd0) begin n_err++; $display("FAIL ar_stat_c_rst: got %0d want 0", stat_c_cnt); end
`endif
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_compressed_pair();
    test_straddle();
    test_redirect_skip();
    test_backpressure();
    test_redirect_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
